tlb_op_ctrl: RTL

- Sequencer for TLB maintenance instructions (tlbsrch, tlbrd, tlbwr, tlbfill, invtlb) issued from the EXE stage.
- Owns arbitration of the MMU's shared search port 1 between EXE load/store translation and tlbsrch/invtlb.
- Generates the TLB write strobe and index, including the tlbfill replacement index, and produces CSR update strobes.
- Raises a refetch request after any TLB-modifying operation so that instructions already fetched under stale mappings are discarded.

---
 rtl/tlb_pkg.sv | 19 +
 rtl/tlb_fill_lfsr.sv | 16 +
 rtl/tlb_op_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance sequencer: opcodes, invtlb limit
// and controller state encoding.
package tlb_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  localparam logic [4:0] INVTLB_MAX = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } tlb_state_e;

endpackage

// File: rtl/tlb_fill_lfsr.sv
// Free-running 4-bit Fibonacci LFSR (x^4+x^3+1) supplying the tlbfill
// replacement index; a non-zero seed keeps it out of the lock-up state.
module tlb_fill_lfsr #(
  parameter logic [3:0] SEED = 4'b1011
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] lfsr
);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: accepts one tlb* instruction at a time, owns MMU
// search port 1 arbitration and issues write, invalidate and CSR strobes.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int         TLBNUM    = 16,
  parameter logic [3:0] LFSR_SEED = 4'b1011,
  localparam int        IDXW      = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      op_invtlb,
  input  logic [9:0]      op_inv_asid,
  input  logic [18:0]     op_inv_vppn,
  input  logic            mem_req,
  output logic            mem_grant,
  output logic            inst_tlbsrch,
  output logic            inst_invtlb,
  output logic [4:0]      invtlb_op,
  output logic [9:0]      inv_asid,
  output logic [18:0]     inv_vppn,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  input  logic [IDXW-1:0] csr_tlbidx_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] w_index,
  output logic            srch_we,
  output logic            srch_hit,
  output logic [IDXW-1:0] srch_index,
  output logic            rd_we,
  output logic            op_done,
  output logic            op_ine,
  output logic            refetch_req
);

  tlb_state_e      state, state_nxt;
  logic [2:0]      op_q;
  logic [3:0]      lfsr;
  logic [IDXW-1:0] fill_idx;
  logic            accept;
  logic            inv_ok;
  logic            op_reserved;

  tlb_fill_lfsr #(.SEED(LFSR_SEED)) u_fill_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign fill_idx    = IDXW'(lfsr);
  assign accept      = (state == ST_IDLE) && op_valid;
  assign inv_ok      = (invtlb_op <= INVTLB_MAX);
  assign op_reserved = (op_q > TLBOP_INV);

  // A TLB op presented in IDLE takes port 1 ahead of a load/store.
  assign mem_grant = mem_req && (state == ST_IDLE) && !op_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= TLBOP_SRCH;
      invtlb_op  <= '0;
      inv_asid   <= '0;
      inv_vppn   <= '0;
      srch_hit   <= 1'b0;
      srch_index <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= op_code;
        if (op_code == TLBOP_INV) begin
          invtlb_op <= op_invtlb;
          inv_asid  <= op_inv_asid;
          inv_vppn  <= op_inv_vppn;
        end
      end
      // Search result is only meaningful in the cycle port 1 was ours.
      if (state == ST_EXEC && op_q == TLBOP_SRCH) begin
        srch_hit   <= s1_found;
        srch_index <= s1_found ? s1_index : '0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    op_ready     = 1'b0;
    inst_tlbsrch = 1'b0;
    inst_invtlb  = 1'b0;
    tlb_we       = 1'b0;
    w_index      = '0;
    srch_we      = 1'b0;
    rd_we        = 1'b0;
    op_done      = 1'b0;
    op_ine       = 1'b0;
    refetch_req  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
        case (op_q)
          TLBOP_SRCH: inst_tlbsrch = 1'b1;
          TLBOP_WR: begin
            tlb_we  = 1'b1;
            w_index = csr_tlbidx_index;
          end
          TLBOP_FILL: begin
            tlb_we  = 1'b1;
            w_index = fill_idx;
          end
          TLBOP_INV: inst_invtlb = inv_ok;
          default: ;
        endcase
      end
      ST_RESP: begin
        state_nxt   = ST_IDLE;
        op_done     = 1'b1;
        srch_we     = (op_q == TLBOP_SRCH);
        rd_we       = (op_q == TLBOP_RD);
        op_ine      = op_reserved || (op_q == TLBOP_INV && !inv_ok);
        refetch_req = (op_q == TLBOP_WR) || (op_q == TLBOP_FILL) ||
                      (op_q == TLBOP_INV && inv_ok);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
